alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 104 ++++++++++
 tb/tb_alu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle registered ALU: one operation per valid cycle, result and zero one edge later.
// Optional multiplier for op 11 is enabled by defining ALU_MUL_EN.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASS_B = 5'd10,
    OP_MUL    = 5'd11
  } op_e;

  op_e              w_op;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_sll;
  logic [WIDTH-1:0] w_srl;
  logic [WIDTH-1:0] w_sra;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] w_next;

  logic [WIDTH-1:0] r_result;
  logic             r_out_valid;

  assign w_op    = op_e'(alu_op);
  // Only the low log2(WIDTH) bits of b form the shift amount.
  assign w_shamt = b[SHW-1:0];

  assign w_add  = a + b;
  assign w_sub  = a - b;
  assign w_sll  = a << w_shamt;
  assign w_srl  = a >> w_shamt;
  assign w_sra  = $unsigned($signed(a) >>> w_shamt);
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] w_mul;
  assign w_mul = a * b;
`endif

  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = '0;
    case (w_op)
      OP_ADD:    w_next = w_add;
      OP_SUB:    w_next = w_sub;
      OP_XOR:    w_next = a ^ b;
      OP_OR:     w_next = a | b;
      OP_AND:    w_next = a & b;
      OP_SLL:    w_next = w_sll;
      OP_SRL:    w_next = w_srl;
      OP_SRA:    w_next = w_sra;
      OP_SLT:    w_next = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU:   w_next = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_PASS_B: w_next = b;
`ifdef ALU_MUL_EN
      OP_MUL:    w_next = w_mul;
`endif
      default:   w_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep register updates order-independent.
    if (rst) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_next;
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;
  assign zero      = (r_result == '0);

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected results, a negedge monitor pops and compares.
module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       alu_op;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             zero;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q[$];

  alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model computed from the arithmetic meaning of each op.
  function automatic logic [WIDTH-1:0] model(input int op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint unsigned ux, uy, pow, m;
    longint sx, sy, q;
    int sh;
    ux  = longint'(x);
    uy  = longint'(y);
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    m   = 64'h1_0000_0000;
    sh  = int'(y % 32);
    pow = 64'd1 << sh;
    case (op)
      0:  return WIDTH'((ux + uy) % m);
      1:  return WIDTH'((ux + m - uy) % m);
      2:  return x ^ y;
      3:  return x | y;
      4:  return x & y;
      5:  return WIDTH'((ux * pow) % m);
      6:  return WIDTH'(ux / pow);
      7: begin
        q = sx / longint'(pow);
        if (sx < 0 && q * longint'(pow) != sx) q = q - 1;
        return WIDTH'(q);
      end
      8:  return (sx < sy) ? 1 : 0;
      9:  return (ux < uy) ? 1 : 0;
      10: return y;
`ifdef ALU_MUL_EN
      11: return WIDTH'((ux * uy) % m);
`endif
      default: return '0;
    endcase
  endfunction

  task automatic issue_exp(input int op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic [WIDTH-1:0] exp);
    @(posedge clk);
    #1;
    alu_op   = 5'(op);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    exp_q.push_back(exp);
  endtask

  task automatic issue(input int op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    issue_exp(op, x, y, model(op, x, y));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every valid output must match the oldest queued expectation.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got result 0x%08h with no pending op", result);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", result, e);
          check("sb_zero", {31'd0, zero}, {31'd0, (e == '0)});
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_op = '0;
    #1;
    check("reset_result", result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First op right after reset release is accepted at the first edge.
    issue_exp(0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    issue_exp(1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    issue_exp(5, 32'h8000_0000, 32'h21, 32'h0000_0000);
    issue_exp(6, 32'h8000_0000, 32'h21, 32'h4000_0000);
    issue_exp(7, 32'h8000_0000, 32'h21, 32'hC000_0000);
    issue_exp(8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue_exp(9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    issue_exp(15, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    issue_exp(10, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D);
`ifdef ALU_MUL_EN
    issue_exp(11, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F);
`else
    issue_exp(11, 32'h0001_0003, 32'h0001_0005, 32'd0);
`endif

    // Back-to-back random bitwise/arithmetic ops.
    for (int op = 0; op < 5; op++) begin
      for (int i = 0; i < 1000; i++) begin
        issue(op, $urandom, $urandom);
      end
    end
    // Random mix over all 32 encodings, including shifts and compares.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = rb ^ 32'h1;
      issue(int'($urandom_range(31, 0)), ra, rb);
    end

    // Hold: a valid ADD then idle with changed inputs.
    issue(0, 32'd2, 32'd3);
    idle();
    a = $urandom; b = $urandom; alu_op = 5'd1;
    @(negedge clk);
    @(negedge clk);
    check("hold_result", result, 32'd5);
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_zero", {31'd0, zero}, 32'd0);

    // Mid-stream reset: an op is in flight when rst rises between edges.
    issue(2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    issue(0, 32'd7, 32'd9);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_zero", {31'd0, zero}, 32'd1);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    // The ADD 7+9 was never captured; only the XOR before it may still be queued.
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 32'd40, 32'd2);
    idle();

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
